// File: rtl/plic_mc_pkg.sv
// Shared bus types, register-map offsets and a byte-merge helper for the
// multi-context PLIC.
package plic_mc_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_t;

    typedef struct packed {
        logic [31:0] req_addr;
        logic [31:0] req_data;
        logic [3:0]  req_mask;
        mem_type_t   req_type;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] resp_data;
    } mem_resp_t;

    // Word offsets relative to PLIC_IRQ_N (the PRI array occupies 0..N-1).
    localparam int PLIC_MC_IP_OFS     = 0;
    localparam int PLIC_MC_MODE_OFS   = 1;
    localparam int PLIC_MC_CTX_BASE   = 4;
    localparam int PLIC_MC_CTX_STRIDE = 4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/plic_mc_gateway.sv
// Per-source gateway: 2-flop synchroniser, edge detect, open/EPEND state and
// the interrupt-pending bit itself.
module plic_mc_gateway (
    input  logic clk,
    input  logic rstn,
    input  logic src,
    input  logic edge_mode,
    input  logic claim_clr,
    input  logic complete,
    output logic ip
);

    logic src_s1, src_s2, src_d;
    logic gw_open, epend;
    logic rise, set_ip, open_next, epend_next;

    assign rise = edge_mode & src_s2 & ~src_d;

    always_comb begin
        set_ip     = 1'b0;
        open_next  = gw_open;
        epend_next = epend;
        if (gw_open) begin
            if (epend) begin
                // An edge latched while closed is served as soon as the gate opens.
                set_ip     = 1'b1;
                epend_next = rise;
            end else if (edge_mode ? rise : src_s2) begin
                set_ip = 1'b1;
            end
            if (set_ip) begin
                open_next = 1'b0;
            end
        end else begin
            if (rise) begin
                epend_next = 1'b1;
            end
            if (complete) begin
                if (epend) begin
                    set_ip     = 1'b1;
                    epend_next = rise;
                end else begin
                    open_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_s1  <= 1'b0;
            src_s2  <= 1'b0;
            src_d   <= 1'b0;
            gw_open <= 1'b1;
            epend   <= 1'b0;
            ip      <= 1'b0;
        end else begin
            src_s1  <= src;
            src_s2  <= src_s1;
            src_d   <= src_s2;
            gw_open <= open_next;
            epend   <= epend_next;
            ip      <= (ip & ~claim_clr) | set_ip;
        end
    end

endmodule

// File: rtl/plic_mc.sv
// Multi-context platform-level interrupt controller on the mem_if bus:
// register file, per-context arbitration chains and claim/complete ports.
module plic_mc
    import plic_mc_pkg::*;
#(
    parameter int PLIC_IRQ_N = 32,
    parameter int PLIC_PRI_W = 3,
    parameter int PLIC_CTX_N = 2,
    parameter int PLIC_ID_W  = $clog2(PLIC_IRQ_N)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  mem_req_t              mem_req,
    output logic                  mem_resp_valid,
    input  logic                  mem_resp_ready,
    output mem_resp_t             mem_resp,
    input  logic [PLIC_IRQ_N-1:0] ext_irq_src,
    output logic [PLIC_CTX_N-1:0] ext_irq
);

    localparam logic [9:0] IP_IDX   = 10'(PLIC_IRQ_N + PLIC_MC_IP_OFS);
    localparam logic [9:0] MODE_IDX = 10'(PLIC_IRQ_N + PLIC_MC_MODE_OFS);
    localparam logic [9:0] CTX_IDX  = 10'(PLIC_IRQ_N + PLIC_MC_CTX_BASE);

    logic [PLIC_PRI_W-1:0] pri_q [PLIC_IRQ_N];
    logic [PLIC_IRQ_N-1:0] mode_q;
    logic [PLIC_IRQ_N-1:0] ie_q  [PLIC_CTX_N];
    logic [PLIC_PRI_W-1:0] thr_q [PLIC_CTX_N];
    logic [PLIC_CTX_N-1:0] ext_irq_q;
    logic                  resp_valid_q;
    logic [31:0]           resp_data_q;

    logic [PLIC_IRQ_N-1:0] ip;
    logic [PLIC_PRI_W-1:0] max_pri [PLIC_CTX_N];
    logic [PLIC_ID_W-1:0]  win_id  [PLIC_CTX_N];

    logic                  req_fire, rd_fire, wr_fire, cmpl_hit;
    logic [9:0]            idx;
    logic [31:0]           rd_data, wr_val, cid_full;
    logic [PLIC_ID_W-1:0]  cid;
    logic [PLIC_CTX_N-1:0] claim_ctx;
    logic [PLIC_IRQ_N-1:1] claim_clr, complete_vec;
    logic                  unused_bits;

    // Single outstanding transaction: a request is accepted only while no
    // response is held, and the response holds until valid & ready.
    assign mem_req_ready      = ~resp_valid_q;
    assign mem_resp_valid     = resp_valid_q;
    assign mem_resp.resp_data = resp_data_q;
    assign ext_irq            = ext_irq_q;

    assign req_fire = mem_req_valid & mem_req_ready;
    assign rd_fire  = req_fire & (mem_req.req_type == MEM_READ);
    assign wr_fire  = req_fire & (mem_req.req_type == MEM_WRITE);
    assign idx      = mem_req.req_addr[11:2];
    assign wr_val   = byte_merge(rd_data, mem_req.req_data, mem_req.req_mask);
    assign cid_full = byte_merge(32'h0, mem_req.req_data, mem_req.req_mask);
    assign cid      = cid_full[PLIC_ID_W-1:0];

    assign unused_bits = ^{mem_req.req_addr[31:12], mem_req.req_addr[1:0],
                           ext_irq_src[0], cid_full};

    always_comb begin
        rd_data   = '0;
        claim_ctx = '0;
        cmpl_hit  = 1'b0;
        if (idx < 10'(PLIC_IRQ_N)) begin
            rd_data = 32'(pri_q[idx[PLIC_ID_W-1:0]]);
        end else if (idx == IP_IDX) begin
            rd_data = 32'(ip);
        end else if (idx == MODE_IDX) begin
            rd_data = 32'(mode_q);
        end
        for (int c = 0; c < PLIC_CTX_N; c++) begin
            if (idx == 10'(CTX_IDX + PLIC_MC_CTX_STRIDE * c)) begin
                rd_data = 32'(ie_q[c]);
            end
            if (idx == 10'(CTX_IDX + PLIC_MC_CTX_STRIDE * c + 1)) begin
                rd_data = 32'(thr_q[c]);
            end
            if (idx == 10'(CTX_IDX + PLIC_MC_CTX_STRIDE * c + 2)) begin
                rd_data      = 32'(win_id[c]);
                claim_ctx[c] = 1'b1;
                cmpl_hit     = 1'b1;
            end
        end
    end

    // ID 0 and IDs without a gateway never match, so they are ignored.
    always_comb begin
        claim_clr    = '0;
        complete_vec = '0;
        for (int i = 1; i < PLIC_IRQ_N; i++) begin
            for (int c = 0; c < PLIC_CTX_N; c++) begin
                if (rd_fire && claim_ctx[c] && win_id[c] == PLIC_ID_W'(i)) begin
                    claim_clr[i] = 1'b1;
                end
            end
            complete_vec[i] = wr_fire & cmpl_hit & (cid == PLIC_ID_W'(i));
        end
    end

    assign ip[0] = 1'b0;

    for (genvar i = 1; i < PLIC_IRQ_N; i++) begin : g_gw
        plic_mc_gateway u_gw (
            .clk       (clk),
            .rstn      (rstn),
            .src       (ext_irq_src[i]),
            .edge_mode (mode_q[i]),
            .claim_clr (claim_clr[i]),
            .complete  (complete_vec[i]),
            .ip        (ip[i])
        );
    end

    // Strict '>' keeps the lowest ID on priority ties; PRI 0 never wins.
    for (genvar c = 0; c < PLIC_CTX_N; c++) begin : g_arb
        logic [PLIC_PRI_W-1:0] best_pri;
        logic [PLIC_ID_W-1:0]  best_id;
        always_comb begin
            best_pri = '0;
            best_id  = '0;
            for (int i = 1; i < PLIC_IRQ_N; i++) begin
                if (ip[i] && ie_q[c][i] && pri_q[i] > best_pri) begin
                    best_pri = pri_q[i];
                    best_id  = PLIC_ID_W'(i);
                end
            end
        end
        assign max_pri[c] = best_pri;
        assign win_id[c]  = best_id;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mode_q       <= '0;
            ext_irq_q    <= '0;
            for (int i = 0; i < PLIC_IRQ_N; i++) begin
                pri_q[i] <= '0;
            end
            for (int c = 0; c < PLIC_CTX_N; c++) begin
                ie_q[c]  <= '0;
                thr_q[c] <= '0;
            end
        end else begin
            if (resp_valid_q && mem_resp_ready) begin
                resp_valid_q <= 1'b0;
            end
            if (req_fire) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= (mem_req.req_type == MEM_WRITE) ? 32'h0 : rd_data;
            end
            if (wr_fire) begin
                for (int i = 1; i < PLIC_IRQ_N; i++) begin
                    if (idx == 10'(i)) begin
                        pri_q[i] <= wr_val[PLIC_PRI_W-1:0];
                    end
                end
                if (idx == MODE_IDX) begin
                    mode_q <= {wr_val[PLIC_IRQ_N-1:1], 1'b0};
                end
                for (int c = 0; c < PLIC_CTX_N; c++) begin
                    if (idx == 10'(CTX_IDX + PLIC_MC_CTX_STRIDE * c)) begin
                        ie_q[c] <= {wr_val[PLIC_IRQ_N-1:1], 1'b0};
                    end
                    if (idx == 10'(CTX_IDX + PLIC_MC_CTX_STRIDE * c + 1)) begin
                        thr_q[c] <= wr_val[PLIC_PRI_W-1:0];
                    end
                end
            end
            for (int c = 0; c < PLIC_CTX_N; c++) begin
                ext_irq_q[c] <= (max_pri[c] > thr_q[c]);
            end
        end
    end

endmodule

// File: tb/tb_plic_mc.sv
// Self-checking bench for plic_mc: bus driver tasks, response scoreboard and
// directed interrupt scenarios across two contexts.
module tb_plic_mc;
    import plic_mc_pkg::*;

    localparam int N      = 32;
    localparam int CTX    = 2;
    localparam int IP_I   = 32;
    localparam int MODE_I = 33;
    localparam int IE0    = 36;
    localparam int THR0   = 37;
    localparam int CLM0   = 38;
    localparam int RSV0   = 39;
    localparam int IE1    = 40;
    localparam int THR1   = 41;
    localparam int CLM1   = 42;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           mem_req_valid = 1'b0;
    logic           mem_req_ready;
    mem_req_t       mem_req;
    logic           mem_resp_valid;
    logic           mem_resp_ready = 1'b1;
    mem_resp_t      mem_resp;
    logic [N-1:0]   ext_irq_src = '0;
    logic [CTX-1:0] ext_irq;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    plic_mc #(
        .PLIC_IRQ_N (N),
        .PLIC_PRI_W (3),
        .PLIC_CTX_N (CTX)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req        (mem_req),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp       (mem_resp),
        .ext_irq_src    (ext_irq_src),
        .ext_irq        (ext_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // scoreboard: one expected word per completed response handshake
    always @(negedge clk) begin
        if (rstn && mem_resp_valid && mem_resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", mem_resp.resp_data, 32'hdead_beef);
            end else begin
                check(tag_q.pop_front(), mem_resp.resp_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input int idx, input logic [31:0] data,
                             input logic [3:0] mask);
        mem_req.req_addr = 32'(idx) << 2;
        mem_req.req_data = data;
        mem_req.req_mask = mask;
        mem_req.req_type = wr ? MEM_WRITE : MEM_READ;
        mem_req_valid    = 1'b1;
    endtask

    task automatic bus_op(input string tag, input logic wr, input int idx,
                          input logic [31:0] data, input logic [3:0] mask,
                          input logic [31:0] exp);
        int cnt;
        exp_q.push_back(wr ? 32'h0 : exp);
        tag_q.push_back(tag);
        @(negedge clk);
        drive_req(wr, idx, data, mask);
        cnt = 0;
        while (!mem_req_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check({tag, "_accept_timeout"}, 32'(cnt), 32'(0));
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
        cnt = 0;
        while (!(mem_resp_valid && mem_resp_ready) && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 50) check({tag, "_resp_timeout"}, 32'(cnt), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        bus_op("write", 1'b1, idx, d, 4'hF, 32'h0);
    endtask

    task automatic rd(input string tag, input int idx, input logic [31:0] exp);
        bus_op(tag, 1'b0, idx, 32'h0, 4'hF, exp);
    endtask

    task automatic pulse(input int i);
        @(negedge clk);
        ext_irq_src[i] = 1'b1;
        repeat (3) @(negedge clk);
        ext_irq_src[i] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int pi;
        int pv;
        mem_req = '0;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_ext_irq", 32'(ext_irq), 32'h0);
        check("rst_resp_valid", 32'(mem_resp_valid), 32'h0);
        check("rst_req_ready", 32'(mem_req_ready), 32'h1);
        @(negedge clk);
        rstn = 1'b1;
        rd("rst_ip", IP_I, 32'h0);
        rd("rst_ie0", IE0, 32'h0);
        rd("rst_pri3", 3, 32'h0);

        // level claim / complete
        wr(3, 5);
        wr(IE0, 32'h8);
        @(negedge clk);
        ext_irq_src[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("lvl_irq_edge3", 32'(ext_irq[0]), 32'h0);
        @(posedge clk);
        #1;
        check("lvl_irq_edge4", 32'(ext_irq[0]), 32'h1);
        check("lvl_irq_ctx1", 32'(ext_irq[1]), 32'h0);
        rd("lvl_claim", CLM0, 32'd3);
        check("lvl_irq_drop", 32'(ext_irq[0]), 32'h0);
        rd("lvl_ip_cleared", IP_I, 32'h0);
        wr(CLM0, 3);
        wait_cycles(1);
        check("lvl_irq_reassert", 32'(ext_irq[0]), 32'h1);
        rd("lvl_ip_reset", IP_I, 32'h8);
        ext_irq_src[3] = 1'b0;
        rd("lvl_claim2", CLM0, 32'd3);
        wr(CLM0, 3);
        rd("lvl_ip_idle", IP_I, 32'h0);

        // priority and tie-break
        wr(2, 4);
        wr(5, 4);
        wr(7, 6);
        wr(IE0, 32'hA4);
        @(negedge clk);
        ext_irq_src[2] = 1'b1;
        ext_irq_src[5] = 1'b1;
        ext_irq_src[7] = 1'b1;
        wait_cycles(5);
        rd("pri_ip", IP_I, 32'hA4);
        rd("pri_claim_a", CLM0, 32'd7);
        rd("pri_claim_b", CLM0, 32'd2);
        rd("pri_claim_c", CLM0, 32'd5);
        rd("pri_claim_none", CLM0, 32'd0);
        ext_irq_src[2] = 1'b0;
        ext_irq_src[5] = 1'b0;
        ext_irq_src[7] = 1'b0;
        wait_cycles(3);
        wr(CLM0, 7);
        wr(CLM0, 2);
        wr(CLM0, 5);
        rd("pri_ip_idle", IP_I, 32'h0);

        // threshold and context split
        wr(THR1, 4);
        wr(4, 4);
        wr(IE1, 32'h10);
        @(negedge clk);
        ext_irq_src[4] = 1'b1;
        wait_cycles(6);
        check("thr_irq1_masked", 32'(ext_irq[1]), 32'h0);
        check("thr_irq0_other", 32'(ext_irq[0]), 32'h0);
        wr(THR1, 3);
        wait_cycles(1);
        check("thr_irq1_raised", 32'(ext_irq[1]), 32'h1);
        wr(THR1, 4);
        wait_cycles(1);
        check("thr_irq1_lowered", 32'(ext_irq[1]), 32'h0);
        bus_op("thr_mask0_write", 1'b1, THR1, 32'h7, 4'h0, 32'h0);
        rd("thr_mask0_hold", THR1, 32'h4);
        rd("thr_claim1", CLM1, 32'd4);
        ext_irq_src[4] = 1'b0;
        wait_cycles(3);
        wr(CLM1, 4);
        rd("thr_ip_idle", IP_I, 32'h0);

        // register-map boundaries
        wr(0, 7);
        rd("pri0_zero", 0, 32'h0);
        wr(RSV0, 32'hFFFF_FFFF);
        rd("reserved_zero", RSV0, 32'h0);
        rd("unmapped_zero", 100, 32'h0);
        wr(IP_I, 32'hFFFF_FFFF);
        rd("ip_readonly", IP_I, 32'h0);
        bus_op("ie1_byte1_write", 1'b1, IE1, 32'hFFFF_FFFF, 4'b0010, 32'h0);
        rd("ie1_byte1", IE1, 32'h0000_FF10);
        wr(IE0, 32'h41);
        rd("ie0_bit0", IE0, 32'h40);

        // edge mode with a lost-then-pending second edge
        wr(MODE_I, 32'h41);
        rd("mode_bit0", MODE_I, 32'h40);
        wr(6, 2);
        pulse(6);
        pulse(6);
        rd("edge_ip", IP_I, 32'h40);
        rd("edge_claim", CLM0, 32'd6);
        rd("edge_ip_clr", IP_I, 32'h0);
        wr(CLM0, 6);
        rd("edge_ip_repend", IP_I, 32'h40);
        rd("edge_claim2", CLM0, 32'd6);
        wr(CLM0, 6);
        rd("edge_ip_final", IP_I, 32'h0);
        rd("edge_claim_none", CLM0, 32'd0);

        // backpressure: IE0 read held, second request (IP) waits
        exp_q.push_back(32'h40);
        tag_q.push_back("bp_first");
        exp_q.push_back(32'h0);
        tag_q.push_back("bp_second");
        mem_resp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, IE0, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        drive_req(1'b0, IP_I, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            check("bp_valid_held", 32'(mem_resp_valid), 32'h1);
            check("bp_data_held", mem_resp.resp_data, 32'h40);
            check("bp_ready_low", 32'(mem_req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        mem_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", 32'(mem_resp_valid), 32'h0);
        check("bp_ready_back", 32'(mem_req_ready), 32'h1);
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
        check("bp_second_valid", 32'(mem_resp_valid), 32'h1);
        @(posedge clk);
        #1;

        // random priority write/readback
        for (int k = 0; k < 6; k++) begin
            pi = $urandom_range(1, 31);
            pv = $urandom_range(0, 7);
            wr(pi, 32'(pv));
            rd("rand_pri", pi, 32'(pv));
        end

        // reset mid-transaction
        wr(3, 5);
        wr(IE0, 32'h8);
        @(negedge clk);
        ext_irq_src[3] = 1'b1;
        wait_cycles(6);
        check("rst_pre_irq", 32'(ext_irq[0]), 32'h1);
        mem_resp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, IP_I, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
        check("rst_pre_resp", 32'(mem_resp_valid), 32'h1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_irq", 32'(ext_irq), 32'h0);
        check("rst_mid_valid", 32'(mem_resp_valid), 32'h0);
        check("rst_mid_ready", 32'(mem_req_ready), 32'h1);
        mem_resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rd("rst_post_pri3", 3, 32'h0);
        rd("rst_post_mode", MODE_I, 32'h0);
        wait_cycles(2);
        rd("rst_post_ip", IP_I, 32'h8);
        wr(3, 5);
        wr(IE0, 32'h8);
        wait_cycles(1);
        check("rst_post_irq", 32'(ext_irq[0]), 32'h1);
        ext_irq_src[3] = 1'b0;

        wait_cycles(2);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
